// File: rtl/median_pkg.sv
// Shared types and constants for the 11-input median/sort network.
package median_pkg;
   typedef logic [31:0] data_t;
   localparam int unsigned MEDIAN_N   = 11;
   localparam data_t       MEDIAN_PAD = 32'hFFFF_FFFF;
endpackage

// File: rtl/median_frame_loader.sv
// Stream-to-frame front end for the sort network: collects up to N words per
// frame, pads short frames, and double-buffers so filling overlaps hand-off.
module median_frame_loader
   import median_pkg::*;
#(
   parameter int unsigned  N         = MEDIAN_N,
   parameter int unsigned  W         = $bits(data_t),
   parameter logic [W-1:0] PAD_VALUE = W'(MEDIAN_PAD)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N*W-1:0]         out_data,
   output logic [$clog2(N+1)-1:0] out_count
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned OW = $clog2(N + 1);

   logic [CW-1:0] fill_cnt;
   logic          pending;
   logic          accept;
   logic          last_word;
   logic          complete;
   logic          slot_free;
   logic          load;

   assign in_ready  = !rst && !pending;
   assign accept    = in_valid && in_ready;
   assign last_word = (fill_cnt == CW'(N - 1)) || in_last;
   assign complete  = accept && last_word;
   assign slot_free = !out_valid || out_ready;
   // Output bank loads either straight from a completing accept or from the parked frame.
   assign load      = (complete && slot_free) || (pending && out_ready);

   // Fill counter, parked-frame flag and output handshake state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_cnt  <= '0;
         pending   <= 1'b0;
         out_valid <= 1'b0;
         out_count <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_count <= OW'(fill_cnt) + OW'(1);
            fill_cnt  <= '0;
            pending   <= 1'b0;
         end else begin
            if (out_valid && out_ready)
               out_valid <= 1'b0;
            // A completed frame with a busy output parks with fill_cnt frozen at its last index.
            if (complete)
               pending <= 1'b1;
            else if (accept)
               fill_cnt <= fill_cnt + CW'(1);
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_slot
      logic [W-1:0] fill_q;
      logic [W-1:0] out_q;
      logic [W-1:0] src;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            fill_q <= '0;
         else if (accept && (fill_cnt == CW'(i)))
            fill_q <= in_data;
      end

      // Slot source: pad above the last word, bypass the word being accepted now.
      always_comb begin
         src = fill_q;
         if (CW'(i) > fill_cnt)
            src = PAD_VALUE;
         else if (!pending && (CW'(i) == fill_cnt))
            src = in_data;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            out_q <= '0;
         else if (load)
            out_q <= src;
      end

      assign out_data[i*W +: W] = out_q;
   end

endmodule

// File: tb/tb_median_frame_loader.sv
// Self-checking bench for median_frame_loader: frame-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_median_frame_loader;
   import median_pkg::*;

   localparam int unsigned N  = MEDIAN_N;
   localparam int unsigned W  = 32;
   localparam int unsigned BW = N * W;
   localparam int unsigned OW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [BW-1:0] out_data;
   logic [OW-1:0] out_count;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses[$];

   always #5 clk = ~clk;

   median_frame_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words collected into frames; one parked frame; one shown frame.
   int unsigned   cur[$];
   int unsigned   held[$];
   bit            m_held;
   bit            m_valid;
   logic [BW-1:0] m_data;
   int            m_count;

   function automatic logic [BW-1:0] pack(input int unsigned q[$]);
      logic [BW-1:0] d;
      d = '0;
      for (int i = 0; i < N; i++)
         d[i*W +: W] = (i < q.size()) ? W'(q[i]) : MEDIAN_PAD;
      return d;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit take;
      bit shown;
      if (rst) begin
         cur.delete();
         held.delete();
         m_held  = 1'b0;
         m_valid = 1'b0;
         m_data  = '0;
         m_count = 0;
      end else begin
         take  = m_valid && out_ready;
         shown = 1'b0;
         if (m_held) begin
            if (out_ready) begin
               m_data  = pack(held);
               m_count = held.size();
               m_held  = 1'b0;
               shown   = 1'b1;
            end
         end else if (in_valid) begin
            cur.push_back(in_data);
            if (cur.size() == N || in_last) begin
               if (!m_valid || out_ready) begin
                  m_data  = pack(cur);
                  m_count = cur.size();
                  shown   = 1'b1;
               end else begin
                  held   = cur;
                  m_held = 1'b1;
               end
               cur.delete();
            end
         end
         if (shown)
            m_valid = 1'b1;
         else if (take)
            m_valid = 1'b0;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("in_ready", BW'(in_ready), BW'(!rst && !m_held));
      chk("out_valid", BW'(out_valid), BW'(m_valid));
      if (m_valid || rst) begin
         chk("out_data", out_data, m_data);
         chk("out_count", BW'(out_count), BW'(m_count));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic logic [W-1:0] slot(input int k);
      return out_data[k*W +: W];
   endfunction

   initial begin
      tick();
      tick();
      chk("rst_in_ready", BW'(in_ready), BW'(0));
      chk("rst_out_valid", BW'(out_valid), BW'(0));
      chk("rst_out_count", BW'(out_count), BW'(0));
      chk("rst_out_data", out_data, BW'(0));
      rst = 1'b0;
      #1;
      chk("release_in_ready", BW'(in_ready), BW'(1));

      // Full frame, words 1..11.
      out_ready = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         chk("full_in_ready", BW'(in_ready), BW'(1));
         send(W'(k), 1'b0);
         if (k < 11)
            chk("full_no_early_valid", BW'(out_valid), BW'(0));
      end
      chk("full_valid", BW'(out_valid), BW'(1));
      chk("full_count", BW'(out_count), BW'(11));
      for (int k = 0; k < 11; k++)
         chk("full_slot", BW'(slot(k)), BW'(k + 1));
      tick();
      chk("full_valid_drop", BW'(out_valid), BW'(0));

      // Short frame A..D with in_last on D.
      send(32'hA, 1'b0);
      send(32'hB, 1'b0);
      send(32'hC, 1'b0);
      send(32'hD, 1'b1);
      chk("short_valid", BW'(out_valid), BW'(1));
      chk("short_count", BW'(out_count), BW'(4));
      for (int k = 0; k < 11; k++)
         chk("short_slot", BW'(slot(k)), (k < 4) ? BW'(32'hA + k) : BW'(32'hFFFF_FFFF));
      tick();
      chk("short_valid_drop", BW'(out_valid), BW'(0));

      // Backpressure: 22 words into a blocked output.
      out_ready = 1'b0;
      for (int k = 0; k < 22; k++) begin
         chk("bp_in_ready", BW'(in_ready), BW'(1));
         send(W'(100 + k), 1'b0);
      end
      chk("bp_valid", BW'(out_valid), BW'(1));
      chk("bp_count", BW'(out_count), BW'(11));
      chk("bp_stall_ready", BW'(in_ready), BW'(0));
      for (int k = 0; k < 11; k++)
         chk("bp_frame1", BW'(slot(k)), BW'(100 + k));
      in_valid = 1'b1;
      in_data  = 32'd122;
      tick();
      tick();
      chk("bp_still_stalled", BW'(in_ready), BW'(0));
      chk("bp_hold_slot0", BW'(slot(0)), BW'(100));
      chk("bp_hold_slot10", BW'(slot(10)), BW'(110));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_valid", BW'(out_valid), BW'(1));
      chk("bp_release_ready", BW'(in_ready), BW'(1));
      chk("bp_release_count", BW'(out_count), BW'(11));
      for (int k = 0; k < 11; k++)
         chk("bp_frame2", BW'(slot(k)), BW'(111 + k));
      out_ready = 1'b1;
      tick();
      chk("bp_drain", BW'(out_valid), BW'(0));

      // Streaming: 33 words, three one-cycle pulses 11 cycles apart.
      pulses.delete();
      for (int k = 0; k < 33; k++) begin
         chk("stream_in_ready", BW'(in_ready), BW'(1));
         send(W'(200 + k), 1'b0);
         if (out_valid)
            pulses.push_back(k);
      end
      chk("stream_pulse_count", BW'(pulses.size()), BW'(3));
      for (int p = 0; p < 3; p++)
         chk("stream_pulse_pos", BW'((p < pulses.size()) ? pulses[p] : -1), BW'(10 + 11 * p));
      chk("stream_last_slot0", BW'(slot(0)), BW'(222));
      tick();
      chk("stream_end_valid", BW'(out_valid), BW'(0));

      // Reset mid-fill.
      for (int k = 0; k < 5; k++)
         send(W'(250 + k), 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", BW'(in_ready), BW'(0));
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("midrst_valid", BW'(out_valid), BW'(0));
         chk("midrst_count", BW'(out_count), BW'(0));
         chk("midrst_in_ready_hold", BW'(in_ready), BW'(0));
      end
      rst = 1'b0;
      #1;
      chk("midrst_release_ready", BW'(in_ready), BW'(1));
      for (int k = 0; k < 11; k++)
         send(W'(300 + k), 1'b0);
      chk("postrst_valid", BW'(out_valid), BW'(1));
      chk("postrst_count", BW'(out_count), BW'(11));
      for (int k = 0; k < 11; k++)
         chk("postrst_slot", BW'(slot(k)), BW'(300 + k));
      tick();

      // Reset while a frame is parked.
      out_ready = 1'b0;
      for (int k = 0; k < 22; k++)
         send(W'(400 + k), 1'b0);
      chk("pendrst_parked", BW'(in_ready), BW'(0));
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("pendrst_no_valid", BW'(out_valid), BW'(0));
         chk("pendrst_ready", BW'(in_ready), BW'(1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
